// File: rtl/pdm_cic_sched.sv
// PDM clock generation, CIC control sequencing and round-robin output serializer.
// Optional CIC_SCHED_OVF_CNT_EN adds a saturating overflow counter output ovf_cnt.
module pdm_cic_sched #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 32,
  parameter int CLK_DIV  = 25,
  parameter int DEF_RATE = 64,
  parameter int CH_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              cfg_rate,
  input  logic                     cfg_we,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  output logic                     pdm_clk,
  input  logic [N_CH-1:0]          pdm_din,
  output logic [N_CH-1:0]          cic_din,
  output logic                     cic_new_data,
  output logic                     cic_clk_en,
  output logic                     cic_rst,
  output logic [15:0]              cic_rate,
  output logic                     cic_rate_we,
  input  logic [N_CH*DATA_W-1:0]   cic_out,
  input  logic [N_CH-1:0]          cic_out_rdy,
  output logic [DATA_W-1:0]        m_data,
  output logic [CH_W-1:0]          m_ch,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     ovf
`ifdef CIC_SCHED_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_cnt
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CH_W-1:0] RR_RST = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {CRST, LOAD, RUN} state_e;

  state_e                       state_q, state_d;
  logic                         crst_cnt_q, crst_cnt_d;
  logic [DIV_W-1:0]             div_q, div_d;
  logic                         pdm_clk_q, pdm_clk_d;
  logic [N_CH-1:0]              cic_din_q, cic_din_d;
  logic                         new_data_q, new_data_d;
  logic [15:0]                  rate_q, rate_d;
  logic                         cfg_err_q, cfg_err_d;
  logic                         m_valid_q, m_valid_d;
  logic [DATA_W-1:0]            m_data_q, m_data_d;
  logic [CH_W-1:0]              m_ch_q, m_ch_d;
  logic                         ovf_q, ovf_d;
  logic [N_CH-1:0]              pending_q, pending_d;
  logic [N_CH-1:0][DATA_W-1:0]  hold_q, hold_d;
  logic [CH_W-1:0]              rr_q, rr_d;

  logic                         reconf;
  logic                         term;
  logic                         ld;
  logic                         found;
  logic [CH_W-1:0]              sel;
  logic [DATA_W-1:0]            sel_data;
  logic [N_CH-1:0]              pick;
  logic [N_CH-1:0]              unl;
  logic [N_CH-1:0]              cap;
  logic                         ovf_any;

  // Divider and PDM sampling
  always_comb begin
    term       = (div_q == DIV_W'(CLK_DIV - 1));
    div_d      = term ? '0 : div_q + 1'b1;
    pdm_clk_d  = term ? ~pdm_clk_q : pdm_clk_q;
    cic_din_d  = cic_din_q;
    new_data_d = 1'b0;
    if (term && pdm_clk_q) begin
      cic_din_d  = pdm_din;
      new_data_d = (state_q == RUN);
    end
  end

  // Control FSM
  always_comb begin
    state_d     = state_q;
    crst_cnt_d  = crst_cnt_q;
    rate_d      = rate_q;
    cfg_err_d   = 1'b0;
    reconf      = 1'b0;
    cic_rst     = 1'b0;
    cic_rate_we = 1'b0;
    cic_clk_en  = 1'b0;
    cfg_busy    = 1'b1;
    unique case (state_q)
      CRST: begin
        cic_rst    = 1'b1;
        crst_cnt_d = 1'b1;
        if (crst_cnt_q) begin
          state_d    = LOAD;
          crst_cnt_d = 1'b0;
        end
      end
      LOAD: begin
        cic_rate_we = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        cic_clk_en = 1'b1;
        cfg_busy   = 1'b0;
      end
      default: state_d = CRST;
    endcase
    if (cfg_we) begin
      if (state_q == RUN && cfg_rate >= 16'd4) begin
        reconf     = 1'b1;
        rate_d     = cfg_rate;
        state_d    = CRST;
        crst_cnt_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // Round-robin pick among pending channels, starting after rr_q
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_data = '0;
    pick     = '0;
    for (int k = 1; k <= N_CH; k++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (!found && pending_q[j] &&
            j == (int'(rr_q) + k) % N_CH) begin
          found    = 1'b1;
          sel      = CH_W'(j);
          sel_data = hold_q[j];
          pick[j]  = 1'b1;
        end
      end
    end
  end

  // Capture, overflow and output register
  always_comb begin
    ld        = !m_valid_q || m_ready;
    unl       = (ld && found) ? pick : '0;
    cap       = (state_q == RUN && !reconf) ? cic_out_rdy : '0;
    hold_d    = hold_q;
    pending_d = pending_q;
    ovf_any   = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ch_d    = m_ch_q;
    rr_d      = rr_q;
    for (int i = 0; i < N_CH; i++) begin
      if (cap[i]) begin
        hold_d[i]    = cic_out[i*DATA_W +: DATA_W];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !unl[i]) ovf_any = 1'b1;
      end else if (unl[i]) begin
        pending_d[i] = 1'b0;
      end
    end
    if (ld) begin
      m_valid_d = found;
      if (found) begin
        m_data_d = sel_data;
        m_ch_d   = sel;
        rr_d     = sel;
      end
    end
    if (reconf) begin
      pending_d = '0;
      m_valid_d = 1'b0;
      rr_d      = RR_RST;
    end
    ovf_d = ovf_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CRST;
      crst_cnt_q <= 1'b0;
      div_q      <= '0;
      pdm_clk_q  <= 1'b0;
      cic_din_q  <= '0;
      new_data_q <= 1'b0;
      rate_q     <= 16'(DEF_RATE);
      cfg_err_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_ch_q     <= '0;
      ovf_q      <= 1'b0;
      pending_q  <= '0;
      hold_q     <= '0;
      rr_q       <= RR_RST;
    end else begin
      state_q    <= state_d;
      crst_cnt_q <= crst_cnt_d;
      div_q      <= div_d;
      pdm_clk_q  <= pdm_clk_d;
      cic_din_q  <= cic_din_d;
      new_data_q <= new_data_d;
      rate_q     <= rate_d;
      cfg_err_q  <= cfg_err_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_ch_q     <= m_ch_d;
      ovf_q      <= ovf_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      rr_q       <= rr_d;
    end
  end

`ifdef CIC_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Survives internal CRST entries; only rst or an accepted reconfig clear it
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (reconf) ovf_cnt_d = '0;
    else if (ovf_d && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign pdm_clk      = pdm_clk_q;
  assign cic_din      = cic_din_q;
  assign cic_new_data = new_data_q;
  assign cic_rate     = rate_q;
  assign cfg_err      = cfg_err_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_ch         = m_ch_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_pdm_cic_sched.sv
// Scoreboard bench for pdm_cic_sched: directed stimulus, monitor pops on each
// accepted output beat.
module tb_pdm_cic_sched;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cfg_rate = '0;
  logic          cfg_we = 1'b0;
  logic          cfg_busy, cfg_err, pdm_clk;
  logic [N-1:0]  pdm_din = '0;
  logic [N-1:0]  cic_din;
  logic          cic_new_data, cic_clk_en, cic_rst, cic_rate_we;
  logic [15:0]   cic_rate;
  logic [N*DW-1:0] cic_out = '0;
  logic [N-1:0]  cic_out_rdy = '0;
  logic [DW-1:0] m_data;
  logic [1:0]    m_ch;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          ovf;
`ifdef CIC_SCHED_OVF_CNT_EN
  logic [15:0]   ovf_cnt;
`endif

  pdm_cic_sched #(
    .N_CH(N), .DATA_W(DW), .CLK_DIV(2), .DEF_RATE(64), .CH_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_rate(cfg_rate), .cfg_we(cfg_we),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .pdm_clk(pdm_clk), .pdm_din(pdm_din),
    .cic_din(cic_din), .cic_new_data(cic_new_data),
    .cic_clk_en(cic_clk_en), .cic_rst(cic_rst),
    .cic_rate(cic_rate), .cic_rate_we(cic_rate_we),
    .cic_out(cic_out), .cic_out_rdy(cic_out_rdy),
    .m_data(m_data), .m_ch(m_ch),
    .m_valid(m_valid), .m_ready(m_ready),
    .ovf(ovf)
`ifdef CIC_SCHED_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [DW-1:0] v);
    cic_out[ch*DW +: DW] = v;
    cic_out_rdy[ch] = 1'b1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [DW-1:0] v);
    exp_t x;
    x.ch = ch;
    x.d  = v;
    q.push_back(x);
  endtask

  // Monitor: a beat transfers at the next posedge when valid && ready
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got ch %0d data %0d expected none",
                 m_ch, m_data);
      end else begin
        e = q.pop_front();
        chk("sb_ch", 32'(m_ch), 32'(e.ch));
        chk("sb_data", m_data, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int  rise1, rise2, nrise, ovfs;
  logic prev, cur;

  initial begin
    repeat (3) tick();
    chk("rst_cic_rst", 32'(cic_rst), 1);
    chk("rst_busy", 32'(cfg_busy), 1);
    chk("rst_clk_en", 32'(cic_clk_en), 0);
    chk("rst_rate", 32'(cic_rate), 64);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_pdm_clk", 32'(pdm_clk), 0);
    chk("rst_new_data", 32'(cic_new_data), 0);

    // CRST two cycles, LOAD one, then RUN
    rst = 1'b0;
    chk("crst0", 32'(cic_rst), 1);
    tick();
    chk("crst1", 32'(cic_rst), 1);
    chk("crst1_we", 32'(cic_rate_we), 0);
    chk("crst1_nd", 32'(cic_new_data), 0);
    tick();
    chk("load_rst", 32'(cic_rst), 0);
    chk("load_we", 32'(cic_rate_we), 1);
    chk("load_rate", 32'(cic_rate), 64);
    chk("load_clk_en", 32'(cic_clk_en), 0);
    chk("load_nd", 32'(cic_new_data), 0);
    tick();
    chk("run_clk_en", 32'(cic_clk_en), 1);
    chk("run_busy", 32'(cfg_busy), 0);
    chk("run_we", 32'(cic_rate_we), 0);

    // PDM clock period and sampling strobe
    pdm_din = 4'b1010;
    rise1 = -100;
    rise2 = -100;
    nrise = 0;
    prev = pdm_clk;
    for (int c = 0; c < 24; c++) begin
      tick();
      cur = pdm_clk;
      if (!prev && cur) begin
        if (nrise == 0) rise1 = c;
        else if (nrise == 1) rise2 = c;
        nrise++;
      end
      chk("new_data", 32'(cic_new_data), 32'(prev && !cur));
      if (prev && !cur) chk("cic_din", 32'(cic_din), 32'b1010);
      prev = cur;
    end
    chk("pdm_period", 32'(rise2 - rise1), 4);

    // Reconfiguration to 128
    cfg_rate = 16'd128;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("rc_busy", 32'(cfg_busy), 1);
    chk("rc_rst0", 32'(cic_rst), 1);
    chk("rc_clk_en", 32'(cic_clk_en), 0);
    chk("rc_rate", 32'(cic_rate), 128);
    chk("rc_err0", 32'(cfg_err), 0);
    tick();
    chk("rc_rst1", 32'(cic_rst), 1);
    tick();
    chk("rc_load_we", 32'(cic_rate_we), 1);
    chk("rc_load_rate", 32'(cic_rate), 128);
    chk("rc_load_rst", 32'(cic_rst), 0);
    cfg_rate = 16'd200;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("load_we_err", 32'(cfg_err), 1);
    chk("load_we_rate", 32'(cic_rate), 128);
    chk("load_we_busy", 32'(cfg_busy), 0);
    tick();
    chk("err_pulse_end", 32'(cfg_err), 0);
    cfg_rate = 16'd3;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("rate3_err", 32'(cfg_err), 1);
    chk("rate3_rate", 32'(cic_rate), 128);
    chk("rate3_busy", 32'(cfg_busy), 0);
    cfg_rate = 16'd4;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("rate4_busy", 32'(cfg_busy), 1);
    chk("rate4_rate", 32'(cic_rate), 4);
    chk("rate4_err", 32'(cfg_err), 0);
    repeat (3) tick();
    chk("rate4_run", 32'(cfg_busy), 0);

    // All four channels ready at once
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      put(i, 32'(10 + i));
      push(2'(i), 32'(10 + i));
    end
    tick();
    cic_out_rdy = '0;
    chk("lat_t1", 32'(m_valid), 0);
    tick();
    chk("lat_t2", 32'(m_valid), 1);
    chk("lat_ch", 32'(m_ch), 0);
    chk("lat_data", m_data, 10);
    repeat (4) tick();
    chk("burst_drained", 32'(q.size()), 0);
    chk("burst_idle", 32'(m_valid), 0);

    // Arrival in the same cycle as unload: no overflow
    m_ready = 1'b0;
    put(1, 32'd7);
    tick();
    cic_out_rdy = '0;
    put(1, 32'd8);
    ovfs = 0;
    tick();
    ovfs += int'(ovf);
    cic_out_rdy = '0;
    repeat (3) begin
      tick();
      ovfs += int'(ovf);
    end
    chk("same_cycle_ovf", 32'(ovfs), 0);
    push(2'd1, 32'd7);
    push(2'd1, 32'd8);
    m_ready = 1'b1;
    repeat (3) tick();
    chk("same_cycle_drain", 32'(q.size()), 0);

    // Overwrite of a pending sample under stall
    m_ready = 1'b0;
    put(0, 32'd99);
    tick();
    cic_out_rdy = '0;
    repeat (2) tick();
    chk("stall_valid", 32'(m_valid), 1);
    chk("stall_ch0", 32'(m_ch), 0);
    push(2'd0, 32'd99);
    ovfs = 0;
    put(2, 32'd5);
    tick();
    ovfs += int'(ovf);
    cic_out_rdy = '0;
    put(2, 32'd6);
    tick();
    ovfs += int'(ovf);
    cic_out_rdy = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      ovfs += int'(ovf);
      chk("stall_data", m_data, 99);
      chk("stall_ch", 32'(m_ch), 0);
      chk("stall_v", 32'(m_valid), 1);
    end
    chk("ovf_pulses", 32'(ovfs), 1);
`ifdef CIC_SCHED_OVF_CNT_EN
    chk("ovf_cnt", 32'(ovf_cnt), 1);
`endif
    push(2'd2, 32'd6);
    m_ready = 1'b1;
    repeat (3) tick();
    chk("ovf_drain", 32'(q.size()), 0);

    // Reconfig mid-stall drops everything in flight
    m_ready = 1'b0;
    put(3, 32'd42);
    put(1, 32'd77);
    tick();
    cic_out_rdy = '0;
    repeat (2) tick();
    chk("mid_valid", 32'(m_valid), 1);
    chk("mid_ch", 32'(m_ch), 3);
    cfg_rate = 16'd64;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("mid_cleared", 32'(m_valid), 0);
`ifdef CIC_SCHED_OVF_CNT_EN
    chk("ovf_cnt_clr", 32'(ovf_cnt), 0);
`endif
    repeat (3) tick();
    chk("mid_run", 32'(cfg_busy), 0);
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_pending", 32'(m_valid), 0);
    end

    for (int c = 0; c < 50 && q.size() != 0; c++) tick();
    chk("sb_empty", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
